// File: rtl/cdc_fifo_pkg.sv
// Shared types and constants for the CDC FIFO write-side blocks.
package cdc_fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int FIFO_ADDR_WIDTH = 4;

    typedef enum logic {
        ARB   = 1'b0,
        WRITE = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int result = 0;
        int rem    = value - 1;
        while (rem > 0) begin
            result++;
            rem = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer-side request bus and FIFO write port of the write arbiter.
interface fifo_wr_arbiter_if
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          full;
    logic [NUM_REQ-1:0]            gnt;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         wr_data;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    modport master (
        output req, req_data, full,
        input  gnt, wr_en, wr_data, grant_id, busy
    );

    modport slave (
        input  req, req_data, full,
        output gnt, wr_en, wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter_pick.sv
// Combinational round-robin pick: rotate requests by the pointer, priority
// encode the lowest set bit, then rotate the index back.
module rr_priority_pick #(
    parameter int NUM_REQ  = 4,
    parameter int ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] ptr,
    output logic                found,
    output logic [ID_WIDTH-1:0] win
);
    logic [NUM_REQ-1:0]  rot;
    logic [ID_WIDTH-1:0] rot_idx;
    int                  src_idx;
    int                  win_idx;

    always_comb begin
        rot     = '0;
        found   = 1'b0;
        rot_idx = '0;
        src_idx = 0;
        win_idx = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            src_idx = i + int'(ptr);
            if (src_idx >= NUM_REQ) src_idx = src_idx - NUM_REQ;
            if (src_idx < NUM_REQ) rot[i] = req[ID_WIDTH'(src_idx)];
        end
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found   = 1'b1;
                rot_idx = ID_WIDTH'(i);
            end
        end
        // Modulo by subtraction keeps the wrap correct for non-power-of-two counts.
        win_idx = int'(rot_idx) + int'(ptr);
        if (win_idx >= NUM_REQ) win_idx = win_idx - NUM_REQ;
        win = ID_WIDTH'(win_idx);
    end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the CDC FIFO write port among NUM_REQ producers.
// Define ARB_BURST_EN to let a winner keep priority for up to BURST_LEN grants.
module fifo_wr_arbiter
    import cdc_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = clog2(NUM_REQ),
    parameter int BURST_LEN  = 4
) (
    input  logic             clk,
    input  logic             reset,
    fifo_wr_arbiter_if.slave bus
);
    arb_state_t          state, state_next;
    logic [ID_WIDTH-1:0] ptr, ptr_next;
    logic                found;
    logic [ID_WIDTH-1:0] win;

    logic [NUM_REQ-1:0]    gnt_p0, gnt_d;
    logic [DATA_WIDTH-1:0] wr_data_p0, wr_data_d;
    logic [ID_WIDTH-1:0]   grant_id_p0, grant_id_d;

`ifdef ARB_BURST_EN
    localparam int CNT_W = 4;
    logic [CNT_W-1:0] cnt, cnt_next;
`endif

    function automatic logic [ID_WIDTH-1:0] next_idx(input logic [ID_WIDTH-1:0] idx);
        if (int'(idx) >= NUM_REQ - 1) return '0;
        return idx + 1'b1;
    endfunction

    rr_priority_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_pick (
        .req   (bus.req),
        .ptr   (ptr),
        .found (found),
        .win   (win)
    );

    always_comb begin
        state_next = state;
        ptr_next   = ptr;
        gnt_d      = '0;
        wr_data_d  = wr_data_p0;
        grant_id_d = grant_id_p0;
`ifdef ARB_BURST_EN
        cnt_next   = cnt;
`endif
        case (state)
            ARB: begin
                if (!bus.full && found) begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        gnt_d[i] = (ID_WIDTH'(i) == win);
                        if (ID_WIDTH'(i) == win) wr_data_d = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                    end
                    grant_id_d = win;
                    state_next = WRITE;
`ifdef ARB_BURST_EN
                    if (cnt != '0 && win == grant_id_p0) cnt_next = cnt + 1'b1;
                    else                                 cnt_next = CNT_W'(1);
                end else if (cnt != '0) begin
                    // Burst owner went idle or the FIFO stalled us: hand priority on.
                    ptr_next = next_idx(grant_id_p0);
                    cnt_next = '0;
`endif
                end
            end
            WRITE: begin
                state_next = ARB;
`ifdef ARB_BURST_EN
                if (cnt >= CNT_W'(BURST_LEN)) begin
                    ptr_next = next_idx(grant_id_p0);
                    cnt_next = '0;
                end else begin
                    ptr_next = grant_id_p0;
                end
`else
                ptr_next = next_idx(grant_id_p0);
`endif
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ARB;
            ptr         <= '0;
            gnt_p0      <= '0;
            wr_data_p0  <= '0;
            grant_id_p0 <= '0;
`ifdef ARB_BURST_EN
            cnt         <= '0;
`endif
        end else begin
            state       <= state_next;
            ptr         <= ptr_next;
            gnt_p0      <= gnt_d;
            wr_data_p0  <= wr_data_d;
            grant_id_p0 <= grant_id_d;
`ifdef ARB_BURST_EN
            cnt         <= cnt_next;
`endif
        end
    end

    // The write strobe is exactly the registered WRITE state.
    assign bus.wr_en    = (state == WRITE);
    assign bus.busy     = (state == WRITE);
    assign bus.gnt      = gnt_p0;
    assign bus.wr_data  = wr_data_p0;
    assign bus.grant_id = grant_id_p0;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: modelled producers, directed vectors,
// and a monitor that checks every FIFO write against the expected queue.
module tb_fifo_wr_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    typedef struct {
        int id;
        int data;
    } exp_t;

    logic clk;
    logic reset;

    int   total[NR];
    int   base[NR];
    int   taken[NR];
    exp_t sb[$];
    int   checks;
    int   fails;
    int   nwrites;

    fifo_wr_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus();

    fifo_wr_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .ID_WIDTH   (IW),
        .BURST_LEN  (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Producers: request while words remain, advance data after each gnt.
    always_comb begin
        bus.req      = '0;
        bus.req_data = '0;
        for (int i = 0; i < NR; i++) begin
            bus.req[i]               = (taken[i] < total[i]);
            bus.req_data[i*DW +: DW] = DW'(base[i] + taken[i]);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (reset)            taken[i] = 0;
                else if (bus.gnt[i])  taken[i] = taken[i] + 1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin : monitor
        bit   prev;
        exp_t e;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev = 1'b0;
            end else begin
                if (bus.wr_en || bus.gnt != '0) begin
                    check("gnt_onehot", 32'($onehot(bus.gnt)), 1);
                    check("wr_en_with_gnt", 32'(bus.wr_en), 1);
                    check("busy_with_write", 32'(bus.busy), 1);
                    check("no_back_to_back", 32'(prev), 0);
                    if (sb.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_write: got id %0d data 0x%0h, expected no write",
                                 bus.grant_id, bus.wr_data);
                    end else begin
                        e = sb.pop_front();
                        check("grant_id", 32'(bus.grant_id), e.id);
                        check("wr_data", 32'(bus.wr_data), e.data);
                        check("gnt_vec", 32'(bus.gnt), 32'(1) << e.id);
                    end
                    nwrites++;
                end
                prev = bus.wr_en;
            end
        end
    end

    task automatic expect_w(input int id, input int data);
        exp_t e;
        e.id   = id;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic give(input int id, input int n, input int b);
        base[id]  = b;
        total[id] = taken[id] + n;
    endtask

    task automatic apply_reset();
        for (int i = 0; i < NR; i++) total[i] = 0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic drain(input int maxc);
        int n = 0;
        while (sb.size() != 0 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w0;
        int hit;
        checks   = 0;
        fails    = 0;
        nwrites  = 0;
        bus.full = 1'b0;
        for (int i = 0; i < NR; i++) begin
            total[i] = 0;
            base[i]  = 0;
        end

        // Reset values
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        check("rst_gnt", 32'(bus.gnt), 0);
        check("rst_wr_en", 32'(bus.wr_en), 0);
        check("rst_wr_data", 32'(bus.wr_data), 0);
        check("rst_grant_id", 32'(bus.grant_id), 0);
        check("rst_busy", 32'(bus.busy), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Single request from requester 0
        give(0, 1, 'hA5);
        expect_w(0, 'hA5);
        @(posedge clk); #1;
        check("t1_wr_en", 32'(bus.wr_en), 1);
        check("t1_gnt", 32'(bus.gnt), 'b0001);
        check("t1_busy", 32'(bus.busy), 1);
        @(posedge clk); #1;
        check("t1_idle_wr_en", 32'(bus.wr_en), 0);
        check("t1_idle_gnt", 32'(bus.gnt), 0);
        check("t1_idle_busy", 32'(bus.busy), 0);
        drain(20);

        // All four requesting, two words each
        apply_reset();
        give(0, 2, 'h10);
        give(1, 2, 'h20);
        give(2, 2, 'h30);
        give(3, 2, 'h40);
`ifdef ARB_BURST_EN
        expect_w(0, 'h10); expect_w(0, 'h11); expect_w(1, 'h20); expect_w(1, 'h21);
        expect_w(2, 'h30); expect_w(2, 'h31); expect_w(3, 'h40); expect_w(3, 'h41);
`else
        expect_w(0, 'h10); expect_w(1, 'h20); expect_w(2, 'h30); expect_w(3, 'h40);
        expect_w(0, 'h11); expect_w(1, 'h21); expect_w(2, 'h31); expect_w(3, 'h41);
`endif
        w0 = nwrites;
        repeat (16) @(negedge clk);
        check("t2_writes_in_16", 32'(nwrites - w0), 8);
        drain(20);

        // Stall on full, then release
        apply_reset();
        bus.full = 1'b1;
        give(1, 1, 'h61);
        give(2, 1, 'h62);
        w0 = nwrites;
        repeat (10) @(negedge clk);
        check("t3_stall_writes", 32'(nwrites - w0), 0);
        check("t3_stall_busy", 32'(bus.busy), 0);
        expect_w(1, 'h61);
        expect_w(2, 'h62);
        bus.full = 1'b0;
        drain(20);

        // Pointer at 2 after grant to 1, then wrap 3 -> 0
        apply_reset();
        give(1, 1, 'h71);
        expect_w(1, 'h71);
        drain(20);
        give(0, 1, 'h70);
        give(3, 1, 'h73);
        expect_w(3, 'h73);
        expect_w(0, 'h70);
        drain(20);

        // Two requesters held busy
        apply_reset();
        give(0, 5, 'h80);
        give(1, 4, 'h90);
`ifdef ARB_BURST_EN
        expect_w(0, 'h80); expect_w(0, 'h81); expect_w(0, 'h82); expect_w(0, 'h83);
        expect_w(1, 'h90); expect_w(1, 'h91); expect_w(1, 'h92); expect_w(1, 'h93);
        expect_w(0, 'h84);
`else
        expect_w(0, 'h80); expect_w(1, 'h90); expect_w(0, 'h81); expect_w(1, 'h91);
        expect_w(0, 'h82); expect_w(1, 'h92); expect_w(0, 'h83); expect_w(1, 'h93);
        expect_w(0, 'h84);
`endif
        drain(100);

        // Reset asserted while a write to requester 2 is on the port
        apply_reset();
        give(2, 1, 'hC2);
        hit = 0;
        for (int k = 0; k < 10 && hit == 0; k++) begin
            @(posedge clk); #1;
            if (bus.gnt[2]) hit = 1;
        end
        check("t6_gnt2_seen", 32'(hit), 1);
        check("t6_wr_en_before", 32'(bus.wr_en), 1);
        #1 reset = 1'b1;
        #1;
        check("t6_async_gnt", 32'(bus.gnt), 0);
        check("t6_async_wr_en", 32'(bus.wr_en), 0);
        repeat (2) @(negedge clk);
        expect_w(2, 'hC2);
        reset = 1'b0;
        @(posedge clk); #1;
        check("t6_regrant_wr_en", 32'(bus.wr_en), 1);
        check("t6_regrant_id", 32'(bus.grant_id), 2);
        drain(20);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the asynchronous CDC FIFO among NUM_REQ BRAM-side producers.
- Sits between the producer engines and the FIFO write domain.
- Samples requests, honours `full`, and issues one registered write per grant with a one-hot grant acknowledge back to the winner.

Parameters:
- DATA_WIDTH, 8, width of each requester word and of the FIFO write data.
- NUM_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, width of grant index; must equal clog2(NUM_REQ).
- BURST_LEN, 4, maximum consecutive words per grant when ARB_BURST_EN is defined (1..15).

Ports:
- clk  input  1  write-domain clock.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; bit i high = word pending.
- req_data  input  NUM_REQ*DATA_WIDTH  packed words; slice i = req_data[i*DATA_WIDTH +: DATA_WIDTH].
- full  input  1  FIFO full flag, write-domain synchronous.
- gnt  output  NUM_REQ  one-hot, one-cycle acknowledge: word of requester i was written.
- wr_en  output  1  FIFO write strobe, one cycle.
- wr_data  output  DATA_WIDTH  FIFO write data, valid when wr_en=1.
- grant_id  output  ID_WIDTH  index of last winner, held until next grant.
- busy  output  1  high while in state WRITE.

Behaviour:
- Reset is asynchronous, active-high; reset clk.
- Reset values: gnt=0, wr_en=0, wr_data=0, grant_id=0, busy=0, state=ARB, rr pointer=0 (requester 0 highest priority first), burst counter=0.
- FSM state ARB:
  - If full=0 and |req=1, select winner w = first set req bit searching from the rr pointer upward, modulo NUM_REQ.
  - Register wr_en=1, wr_data=req_data slice w, gnt[w]=1, grant_id=w, busy=1.
  - Next state is WRITE.
  - If full=1 or req=0, all strobes stay 0 and the FSM stays in ARB.
- FSM state WRITE:
  - wr_en and gnt return to 0; busy=0; next state is ARB.
  - req is not sampled in WRITE. This gives requesters one cycle after gnt to advance data or drop req.
  - Rr pointer is updated to w+1 (wrap NUM_REQ-1 -> 0).
- Latency: req sampled at edge T produces wr_en/gnt visible after edge T. Peak throughput is 1 word per 2 cycles.
- Exactly one wr_en per gnt; gnt and wr_en assert in the same cycle; never more than one gnt bit set.
- full rises on the same edge the write is issued: the write is still issued, because full was sampled low. The FIFO must tolerate this, as its full is registered with one-entry margin.
- full is high for many cycles: the arbiter stalls in ARB with no writes; fairness state is preserved.
- A requester dropping req while in WRITE has no effect on the word already written.
- reset asserted mid-WRITE: wr_en and gnt clear immediately (async); the word may or may not be captured by the FIFO, and requesters must treat reset as a flush.
- Pointer arithmetic wraps modulo NUM_REQ; it is correct for non-power-of-two NUM_REQ.

Optional Feature:
- Macro name is ARB_BURST_EN.
- When defined:
  - The winner keeps priority for up to BURST_LEN consecutive grants while its req stays high and full=0.
  - The burst counter increments per grant.
  - The rr pointer advances only when the counter reaches BURST_LEN, the winner's req is low in ARB, or full stalls arbitration. The counter then resets to 0.
- When undefined: pure round-robin, pointer advances after every grant, no burst counter logic synthesized.

Decomposition:
- Shared package `cdc_fifo_pkg` holds:
  - default DATA_WIDTH=8 and ADDR_WIDTH=4 constants;
  - state encoding ARB=1'b0 and WRITE=1'b1;
  - a clog2 function.
- One sub-module is natural: `rr_priority_pick`, purely combinational. It takes the req vector and rr pointer and returns a found flag plus the winner index, using a rotate, priority encode and un-rotate.

Test Plan:
- Reset, then req=4'b0001 with req_data slice0=8'hA5 and full=0: wr_en pulses one cycle with wr_data=8'hA5, gnt=4'b0001, grant_id=0, followed by one idle cycle.
- req=4'b1111 held, each requester advancing data after its gnt: grant order is 0,1,2,3,0. wr_en appears every other cycle and exactly 8 writes occur in 16 cycles.
- req=4'b0110 with full held at 1 for 10 cycles: no wr_en and no gnt. Then full=0 gives the next grant to index 1, then index 2.
- req=4'b1001 with the pointer at 2 after a grant to 1: the winner is 3, then 0 (wrap).
- ARB_BURST_EN defined, BURST_LEN=4, req=4'b0011 held: grants are 0,0,0,0,1,1,1,1,0. Without the macro the same stimulus gives 0,1,0,1.
- Assert reset while gnt[2]=1 and wr_en=1: gnt and wr_en drop before the next clk edge. After release, the pointer is 0, and req=4'b0100 is granted to 2 on the first ARB cycle.
